// File: rtl/mux_nto1_arb_pkg.sv
// Shared definitions for the N:1 arbitrated multiplexer: arbitration mode
// encodings and a one-hot to index helper sized for the largest supported N.
package mux_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int MAX_N     = 16;
  localparam int MAX_IDX_W = 4;

  // OR-reduction of set-bit positions; exact for one-hot and zero inputs.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_nto1_arb_if.sv
// Producer/consumer bundle for mux_nto1_arb: per-channel valid/ready/data in,
// one registered valid/ready/data/sel stream out, plus arbitration controls.
interface mux_nto1_arb_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  localparam int SW = $clog2(N)
) ();

  logic           mode;
  logic [N-1:0]   chan_en;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  modport master (
    output mode, chan_en, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  mode, chan_en, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/mux_nto1_arb_rr_arbiter.sv
// Combinational arbiter: scans requests starting at ptr (round robin) or at 0
// (fixed priority), wrapping mod N, and returns a one-hot grant and its index.
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_ptr,
  input  logic          i_mode,
  output logic [N-1:0]  o_grant,
  output logic [SW-1:0] o_idx
);

  int                   w_base;
  int                   w_pos;
  logic                 w_found;
  logic [MAX_IDX_W-1:0] w_idx_full;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_pos   = 0;
    w_base  = (i_mode == MODE_RR) ? int'(i_ptr) : 0;
    for (int k = 0; k < N; k++) begin
      w_pos = w_base + k;
      if (w_pos >= N) w_pos = w_pos - N;
      if (!w_found && i_req[w_pos]) begin
        o_grant[w_pos] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

  assign w_idx_full = onehot_to_idx(MAX_N'(o_grant));
  assign o_idx      = w_idx_full[SW-1:0];

endmodule

// File: rtl/mux_nto1_arb.sv
// N-input arbitrated multiplexer with a single registered output stage that
// loads whenever it is empty or being drained, giving one word per cycle.
module mux_nto1_arb
  import mux_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  mux_nto1_arb_if.slave   bus
);

  logic [N-1:0]  w_req;
  logic          w_load;
  logic [N-1:0]  w_grant;
  logic [SW-1:0] w_idx;
  logic [W-1:0]  w_sel_data;
  logic [SW-1:0] w_ptr_next;

  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_sel;
  logic [SW-1:0] r_rr_ptr;

  assign w_req  = bus.in_valid & bus.chan_en;
  assign w_load = !r_out_valid || bus.out_ready;

  rr_arbiter #(.N(N)) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .i_mode  (bus.mode),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // AND-OR select driven by the one-hot grant.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) w_sel_data = w_sel_data | bus.in_data[i*W +: W];
    end
  end

  assign w_ptr_next   = (w_idx == SW'(N-1)) ? '0 : w_idx + SW'(1);
  assign bus.in_ready = (w_load && !rst) ? w_grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      if (|w_req) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_idx;
        if (bus.mode == MODE_RR) r_rr_ptr <= w_ptr_next;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_nto1_arb.sv
// Directed bench for mux_nto1_arb (N=4, W=8): a per-cycle vector table plus
// hand-built backpressure and mid-operation reset sequences.
module tb_mux_nto1_arb;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [3:0]  en;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_ir;
    logic        exp_v;
    logic        chk_d;
    logic [7:0]  exp_d;
    logic [1:0]  exp_s;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  mux_nto1_arb_if #(.N(N), .W(W)) bus ();

  mux_nto1_arb #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic m, input logic [3:0] en,
                              input logic [3:0] vl, input logic [31:0] d, input logic ordy,
                              input logic [3:0] ir, input logic v, input logic cd,
                              input logic [7:0] ed, input logic [1:0] es);
    vec_t t;
    t.rst = r; t.mode = m; t.en = en; t.valid = vl; t.data = d; t.ordy = ordy;
    t.exp_ir = ir; t.exp_v = v; t.chk_d = cd; t.exp_d = ed; t.exp_s = es;
    return t;
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, step, act, exp);
    end
  endtask

  // Entered just after a rising edge: drive, check the same-cycle in_ready,
  // then check the registered outputs after the next edge.
  task automatic apply(input vec_t v, input int step);
    rst           = v.rst;
    bus.mode      = v.mode;
    bus.chan_en   = v.en;
    bus.in_valid  = v.valid;
    bus.in_data   = v.data;
    bus.out_ready = v.ordy;
    #2;
    chk("in_ready", step, 32'(bus.in_ready), 32'(v.exp_ir));
    @(posedge clk);
    #1;
    chk("out_valid", step, 32'(bus.out_valid), 32'(v.exp_v));
    if (v.chk_d) begin
      chk("out_data", step, 32'(bus.out_data), 32'(v.exp_d));
      chk("out_sel", step, 32'(bus.out_sel), 32'(v.exp_s));
    end
  endtask

  localparam logic [31:0] DFP = 32'hC300_A100;
  localparam logic [31:0] DRR = 32'h3020_1000;

  vec_t tbl [19];

  initial begin
    tbl[0]  = mk(1, 0, 4'b1111, 4'b0000, 32'h0, 0, 4'b0000, 0, 1, 8'h00, 0);
    tbl[1]  = mk(1, 0, 4'b1111, 4'b1111, DRR,   1, 4'b0000, 0, 1, 8'h00, 0);
    tbl[2]  = mk(0, 0, 4'b1111, 4'b0000, 32'h0, 1, 4'b0000, 0, 1, 8'h00, 0);
    tbl[3]  = mk(0, 0, 4'b1111, 4'b1010, DFP,   1, 4'b0010, 1, 1, 8'hA1, 1);
    tbl[4]  = mk(0, 0, 4'b1111, 4'b1010, DFP,   1, 4'b0010, 1, 1, 8'hA1, 1);
    tbl[5]  = mk(0, 0, 4'b1111, 4'b1010, DFP,   1, 4'b0010, 1, 1, 8'hA1, 1);
    tbl[6]  = mk(0, 0, 4'b1111, 4'b1000, DFP,   1, 4'b1000, 1, 1, 8'hC3, 3);
    tbl[7]  = mk(0, 0, 4'b1111, 4'b0000, DFP,   1, 4'b0000, 0, 0, 8'h00, 0);
    tbl[8]  = mk(0, 1, 4'b1111, 4'b1111, DRR,   1, 4'b0001, 1, 1, 8'h00, 0);
    tbl[9]  = mk(0, 1, 4'b1111, 4'b1111, DRR,   1, 4'b0010, 1, 1, 8'h10, 1);
    tbl[10] = mk(0, 1, 4'b1111, 4'b1111, DRR,   1, 4'b0100, 1, 1, 8'h20, 2);
    tbl[11] = mk(0, 1, 4'b1111, 4'b1111, DRR,   1, 4'b1000, 1, 1, 8'h30, 3);
    tbl[12] = mk(0, 1, 4'b1111, 4'b1111, DRR,   1, 4'b0001, 1, 1, 8'h00, 0);
    tbl[13] = mk(0, 1, 4'b1111, 4'b0100, DRR,   1, 4'b0100, 1, 1, 8'h20, 2);
    tbl[14] = mk(0, 1, 4'b0111, 4'b1001, DRR,   1, 4'b0001, 1, 1, 8'h00, 0);
    tbl[15] = mk(0, 1, 4'b1111, 4'b1111, DRR,   1, 4'b0010, 1, 1, 8'h10, 1);
    tbl[16] = mk(0, 0, 4'b1111, 4'b1111, DRR,   1, 4'b0001, 1, 1, 8'h00, 0);
    tbl[17] = mk(0, 1, 4'b1111, 4'b1111, DRR,   1, 4'b0100, 1, 1, 8'h20, 2);
    tbl[18] = mk(0, 1, 4'b1111, 4'b0000, 32'h0, 1, 4'b0000, 0, 0, 8'h00, 0);

    rst = 1'b1;
    bus.mode = 1'b0; bus.chan_en = '0; bus.in_valid = '0;
    bus.in_data = '0; bus.out_ready = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) apply(tbl[i], i);

    // Backpressure: hold 0x55 for three cycles, ch0 enable dropped meanwhile.
    apply(mk(0, 0, 4'b1111, 4'b0001, 32'h0000_0055, 1, 4'b0001, 1, 1, 8'h55, 0), 100);
    for (int i = 0; i < 3; i++)
      apply(mk(0, 0, 4'b1110, 4'b0100, 32'h0022_0055, 0, 4'b0000, 1, 1, 8'h55, 0), 101 + i);
    apply(mk(0, 0, 4'b1110, 4'b0100, 32'h0022_0055, 1, 4'b0100, 1, 1, 8'h22, 2), 104);
    apply(mk(0, 0, 4'b1111, 4'b0000, 32'h0, 1, 4'b0000, 0, 0, 8'h00, 0), 105);

    // Mid-operation reset: 0x77 held with rr_ptr=3, then rst for one cycle.
    apply(mk(0, 1, 4'b1111, 4'b0100, 32'h0077_0000, 1, 4'b0100, 1, 1, 8'h77, 2), 200);
    apply(mk(1, 1, 4'b1111, 4'b0000, 32'h0, 0, 4'b0000, 0, 1, 8'h00, 0), 201);
    apply(mk(0, 1, 4'b1111, 4'b1111, DRR, 1, 4'b0001, 1, 1, 8'h00, 0), 202);
    apply(mk(0, 1, 4'b1111, 4'b0000, 32'h0, 1, 4'b0000, 0, 1, 8'h00, 0), 203);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
